// File: rtl/decision_mux_queue.sv
// Collects per-channel trading decisions, timestamps them, and merges them
// round-robin into one FWFT queue with a saturating drop counter.

module dmq_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         gnt,
    input  logic [W-1:0] din,
    output logic         occ,
    output logic         drop,
    output logic [W-1:0] dout
);
    // A grant frees the slot on the same edge, so a concurrent strobe refills it.
    assign drop = load && occ && !gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ  <= 1'b0;
            dout <= '0;
        end else if (load && (!occ || gnt)) begin
            occ  <= 1'b1;
            dout <= din;
        end else if (gnt) begin
            occ  <= 1'b0;
        end
    end
endmodule

module decision_mux_queue #(
    parameter int N_CH    = 2,
    parameter int TYPE_W  = 8,
    parameter int PRICE_W = 16,
    parameter int SIZE_W  = 16,
    parameter int DEPTH   = 16,
    parameter int TS_W    = 32,
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_CH-1:0]           in_valid,
    input  logic [N_CH*TYPE_W-1:0]    in_msg_type,
    input  logic [N_CH*PRICE_W-1:0]   in_price,
    input  logic [N_CH*SIZE_W-1:0]    in_size,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [TYPE_W-1:0]         out_msg_type,
    output logic [PRICE_W-1:0]        out_price,
    output logic [SIZE_W-1:0]         out_size,
    output logic [CH_W-1:0]           out_channel,
    output logic [TS_W-1:0]           out_ts,
    output logic [AW:0]               fifo_count,
    output logic [15:0]               drop_count
);
    typedef struct packed {
        logic [TYPE_W-1:0]  msg_type;
        logic [PRICE_W-1:0] price;
        logic [SIZE_W-1:0]  size;
        logic [CH_W-1:0]    ch;
        logic [TS_W-1:0]    ts;
    } entry_t;

    logic [TS_W-1:0]        ts_q;
    logic [N_CH-1:0]        occ, gnt, drop, req_hi;
    entry_t [N_CH-1:0]      slot_din, slot_q;
    entry_t                 push_data, head;
    entry_t                 mem [DEPTH];
    logic [CH_W-1:0]        rr_ptr, gnt_idx;
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic                   found, push, pop, push_ok;
    logic [16:0]            drop_sum, drop_next;

    assign pop     = out_valid && out_ready;
    assign push_ok = (fifo_count != (AW+1)'(DEPTH)) || pop;
    assign push    = found;

    for (genvar i = 0; i < N_CH; i++) begin : g_slot
        assign slot_din[i] = {in_msg_type[i*TYPE_W +: TYPE_W], in_price[i*PRICE_W +: PRICE_W],
                              in_size[i*SIZE_W +: SIZE_W], CH_W'(i), ts_q};
        dmq_slot #(.W($bits(entry_t))) u_slot (
            .clk  (clk),
            .rst_n(rst_n),
            .load (in_valid[i]),
            .gnt  (gnt[i]),
            .din  (slot_din[i]),
            .occ  (occ[i]),
            .drop (drop[i]),
            .dout (slot_q[i])
        );
    end

    // Lowest occupied index at or above rr_ptr wins; otherwise wrap to lowest overall.
    always_comb begin
        req_hi    = '0;
        found     = 1'b0;
        gnt_idx   = '0;
        push_data = '0;
        for (int i = 0; i < N_CH; i++) req_hi[i] = occ[i] && (i >= int'(rr_ptr));
        for (int i = N_CH-1; i >= 0; i--) begin
            if (occ[i]) begin
                found   = 1'b1;
                gnt_idx = CH_W'(i);
            end
        end
        if (req_hi != '0) begin
            for (int i = N_CH-1; i >= 0; i--) if (req_hi[i]) gnt_idx = CH_W'(i);
        end
        if (!push_ok) found = 1'b0;
        gnt = found ? (N_CH'(1) << gnt_idx) : '0;
        for (int i = 0; i < N_CH; i++) if (gnt[i]) push_data = slot_q[i];
    end

    always_comb begin
        drop_sum = '0;
        for (int i = 0; i < N_CH; i++) drop_sum = drop_sum + 17'(drop[i]);
        drop_next = {1'b0, drop_count} + drop_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q       <= '0;
            rr_ptr     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            drop_count <= '0;
        end else begin
            ts_q       <= ts_q + 1'b1;
            drop_count <= drop_next[16] ? 16'hFFFF : drop_next[15:0];
            if (found) rr_ptr <= (gnt_idx == CH_W'(N_CH-1)) ? '0 : gnt_idx + 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Storage needs no reset: fifo_count gates everything visible.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head         = mem[rd_ptr];
    assign out_valid    = (fifo_count != '0);
    assign out_msg_type = out_valid ? head.msg_type : '0;
    assign out_price    = out_valid ? head.price    : '0;
    assign out_size     = out_valid ? head.size     : '0;
    assign out_channel  = out_valid ? head.ch       : '0;
    assign out_ts       = out_valid ? head.ts       : '0;
endmodule
